// File: rtl/axi4_wr_arbiter.sv
// axi4_wr_arbiter
// Per-slave AXI4 write-channel arbiter. Masters whose AW decodes to this slave
// compete round-robin. The winner then owns the W channel until its WLAST beat
// is accepted. The burst length is checked against the captured AWLEN, and a
// mismatch is flagged for one cycle. Payload muxing is external and is steered
// by grant_idx. This block drives only valid/ready gating and sequencing.
module axi4_wr_arbiter #(
   parameter int NUM_MASTERS = 15,
   parameter int IDX_WIDTH   = 4,
   parameter int LEN_WIDTH   = 8
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic [NUM_MASTERS-1:0]           m_awvalid,
   input  logic [NUM_MASTERS*LEN_WIDTH-1:0] m_awlen,
   input  logic [NUM_MASTERS-1:0]           m_wvalid,
   input  logic [NUM_MASTERS-1:0]           m_wlast,
   input  logic                             s_awready,
   input  logic                             s_wready,
   output logic [NUM_MASTERS-1:0]           m_awready,
   output logic [NUM_MASTERS-1:0]           m_wready,
   output logic                             s_awvalid,
   output logic                             s_wvalid,
   output logic [IDX_WIDTH-1:0]             grant_idx,
   output logic                             busy,
   output logic                             wlast_err
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ADDR = 2'd1,
      ST_DATA = 2'd2
   } state_e;

   // Master NUM_MASTERS-1 is treated as the previous winner out of reset,
   // so master 0 gets first priority.
   localparam logic [IDX_WIDTH-1:0] LAST_GRANT_RST = IDX_WIDTH'(NUM_MASTERS - 1);
   localparam logic [LEN_WIDTH-1:0] CNT_MAX        = {LEN_WIDTH{1'b1}};
   localparam logic [LEN_WIDTH-1:0] CNT_ONE        = LEN_WIDTH'(1);

   state_e                 state_q,      state_d;
   logic [IDX_WIDTH-1:0]   grant_q,      grant_d;
   logic [IDX_WIDTH-1:0]   last_grant_q, last_grant_d;
   logic [LEN_WIDTH-1:0]   len_q,        len_d;
   logic [LEN_WIDTH-1:0]   beat_cnt_q,   beat_cnt_d;
   logic                   busy_q;
   logic                   wlast_err_q,  wlast_err_d;

   logic [LEN_WIDTH-1:0]   awlen_arr [NUM_MASTERS];
   logic [IDX_WIDTH-1:0]   winner;
   logic                   req_any;
   logic                   sel_awvalid;
   logic                   sel_wvalid;
   logic                   sel_wlast;

   // Unpack the flat AWLEN bus so the granted length can be indexed directly.
   for (genvar gi = 0; gi < NUM_MASTERS; gi++) begin : g_awlen
      assign awlen_arr[gi] = m_awlen[gi*LEN_WIDTH +: LEN_WIDTH];
   end

   assign sel_awvalid = m_awvalid[grant_q];
   assign sel_wvalid  = m_wvalid[grant_q];
   assign sel_wlast   = m_wlast[grant_q];

   // Round-robin pick: scan upward from the master after last_grant, wrapping to 0.
   always_comb begin
      int                   cand;
      logic [IDX_WIDTH-1:0] cand_idx;
      logic                 hit;
      cand     = 0;
      cand_idx = '0;
      hit      = 1'b0;
      winner   = '0;
      req_any  = 1'b0;
      for (int k = 1; k <= NUM_MASTERS; k++) begin
         cand     = int'(last_grant_q) + k;
         cand     = (cand >= NUM_MASTERS) ? (cand - NUM_MASTERS) : cand;
         cand_idx = IDX_WIDTH'(cand);
         hit      = !req_any && m_awvalid[cand_idx];
         winner   = hit ? cand_idx : winner;
         req_any  = req_any | hit;
      end
   end

   // Next-state logic and combinational handshake gating.
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_grant_d = last_grant_q;
      len_d        = len_q;
      beat_cnt_d   = beat_cnt_q;
      wlast_err_d  = 1'b0;
      s_awvalid    = 1'b0;
      s_wvalid     = 1'b0;
      m_awready    = '0;
      m_wready     = '0;
      case (state_q)
         ST_IDLE: begin
            if (req_any) begin
               grant_d = winner;
               state_d = ST_ADDR;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ADDR: begin
            // The grant is kept even if the winner withdraws AWVALID.
            s_awvalid          = sel_awvalid;
            m_awready[grant_q] = s_awready;
            if (sel_awvalid && s_awready) begin
               len_d      = awlen_arr[grant_q];
               beat_cnt_d = '0;
               state_d    = ST_DATA;
            end else begin
               state_d = ST_ADDR;
            end
         end
         ST_DATA: begin
            s_wvalid          = sel_wvalid;
            m_wready[grant_q] = s_wready;
            if (sel_wvalid && s_wready) begin
               beat_cnt_d  = (beat_cnt_q == CNT_MAX) ? beat_cnt_q : (beat_cnt_q + CNT_ONE);
               // The flag is set for WLAST on the wrong beat, or for no WLAST on the expected last beat.
               wlast_err_d = sel_wlast ^ (beat_cnt_q == len_q);
               if (sel_wlast) begin
                  last_grant_d = grant_q;
                  state_d      = ST_IDLE;
               end else begin
                  state_d = ST_DATA;
               end
            end else begin
               state_d = ST_DATA;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // State, grant, length and status registers.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q      <= ST_IDLE;
         grant_q      <= '0;
         last_grant_q <= LAST_GRANT_RST;
         len_q        <= '0;
         beat_cnt_q   <= '0;
         busy_q       <= 1'b0;
         wlast_err_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_grant_q <= last_grant_d;
         len_q        <= len_d;
         beat_cnt_q   <= beat_cnt_d;
         busy_q       <= (state_d != ST_IDLE);
         wlast_err_q  <= wlast_err_d;
      end
   end

   assign grant_idx = grant_q;
   assign busy      = busy_q;
   assign wlast_err = wlast_err_q;

endmodule

// File: tb/tb_axi4_wr_arbiter.sv
// Directed, table-driven bench for axi4_wr_arbiter. Inputs are driven 1 time unit
// after the rising edge. Outputs are sampled on the falling edge.
module tb_axi4_wr_arbiter;
   localparam int NM = 15;
   localparam int IW = 4;
   localparam int LW = 8;

   logic              aclk = 1'b0;
   logic              aresetn;
   logic [NM-1:0]     m_awvalid;
   logic [NM*LW-1:0]  m_awlen;
   logic [NM-1:0]     m_wvalid;
   logic [NM-1:0]     m_wlast;
   logic              s_awready;
   logic              s_wready;
   logic [NM-1:0]     m_awready;
   logic [NM-1:0]     m_wready;
   logic              s_awvalid;
   logic              s_wvalid;
   logic [IW-1:0]     grant_idx;
   logic              busy;
   logic              wlast_err;

   logic [LW-1:0]     lens [NM];

   axi4_wr_arbiter #(.NUM_MASTERS(NM), .IDX_WIDTH(IW), .LEN_WIDTH(LW)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .m_awvalid(m_awvalid), .m_awlen(m_awlen), .m_wvalid(m_wvalid), .m_wlast(m_wlast),
      .s_awready(s_awready), .s_wready(s_wready),
      .m_awready(m_awready), .m_wready(m_wready),
      .s_awvalid(s_awvalid), .s_wvalid(s_wvalid),
      .grant_idx(grant_idx), .busy(busy), .wlast_err(wlast_err)
   );

   always #5 aclk = ~aclk;

   always_comb begin
      m_awlen = '0;
      for (int i = 0; i < NM; i++) m_awlen[i*LW +: LW] = lens[i];
   end

   typedef struct packed {
      logic [14:0] maw;
      logic [14:0] mw;
      logic        saw;
      logic        sw;
      logic [3:0]  gi;
      logic        bsy;
      logic        err;
   } outs_t;

   typedef struct {
      logic        rst;
      logic [14:0] aw;
      logic [7:0]  len;
      logic [14:0] wv;
      logic [14:0] wl;
      logic        sar;
      logic        swr;
      outs_t       exp;
   } vec_t;

   vec_t vecs[$];
   int   nchecks = 0;
   int   nerrs   = 0;

   function automatic outs_t cur();
      return {m_awready, m_wready, s_awvalid, s_wvalid, grant_idx, busy, wlast_err};
   endfunction

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      nchecks++;
      if (got !== exp) begin
         nerrs++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   task automatic add(input logic rst, input logic [14:0] aw, input logic [7:0] len,
                      input logic [14:0] wv, input logic [14:0] wl, input logic sar, input logic swr,
                      input logic [14:0] maw, input logic [14:0] mw, input logic saw, input logic sw,
                      input logic [3:0] gi, input logic bsy, input logic err);
      vec_t v;
      v.rst = rst; v.aw = aw; v.len = len; v.wv = wv; v.wl = wl; v.sar = sar; v.swr = swr;
      v.exp = {maw, mw, saw, sw, gi, bsy, err};
      vecs.push_back(v);
   endtask

   task automatic set_in(input logic [14:0] aw, input logic [7:0] len, input logic [14:0] wv,
                         input logic [14:0] wl, input logic sar, input logic swr);
      m_awvalid = aw;
      for (int i = 0; i < NM; i++) lens[i] = len;
      m_wvalid  = wv;
      m_wlast   = wl;
      s_awready = sar;
      s_wready  = swr;
   endtask

   task automatic do_reset();
      aresetn = 1'b0;
      set_in(15'h0, 8'd0, 15'h0, 15'h0, 1'b0, 1'b0);
      @(posedge aclk);
      @(negedge aclk);
      chk("reset_outputs", 64'(cur()), 64'd0);
      @(posedge aclk);
      #1 aresetn = 1'b1;
   endtask

   task automatic step();
      @(posedge aclk);
      #1;
   endtask

   // One burst from IDLE: nb beats with WLAST on the last. Collects the wlast_err pulse per beat.
   task automatic run_len(input string name, input int m, input logic [7:0] len, input int nb,
                          input logic [7:0] exp_mask);
      logic [7:0]  mask;
      logic [14:0] bit_m;
      mask  = 8'd0;
      bit_m = 15'd1 << m;
      lens[m] = len;
      m_awvalid = bit_m; m_wvalid = 15'h0; m_wlast = 15'h0; s_awready = 1'b1; s_wready = 1'b1;
      @(negedge aclk); step();
      @(negedge aclk);
      chk({name, "_awready"}, 64'(m_awready), 64'(bit_m));
      step();
      m_awvalid = 15'h0;
      for (int b = 0; b <= nb; b++) begin
         m_wvalid = (b < nb) ? bit_m : 15'h0;
         m_wlast  = (b == nb - 1) ? bit_m : 15'h0;
         @(negedge aclk);
         if (b > 0) mask[b-1] = wlast_err;
         if (b == nb) chk({name, "_idle"}, 64'(busy), 64'd0);
         step();
      end
      chk({name, "_err_mask"}, 64'(mask), 64'(exp_mask));
      lens[m] = 8'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish within time limit");
      $fatal(1, "watchdog");
   end

   initial begin
      int viol, addr_ok, acc, badready, errs;
      logic done;

      // Single write: master 3, AWLEN=3, slave always ready.
      add(1'b1, 15'h0008, 8'd3, 15'h0000, 15'h0000, 1'b1, 1'b1, 15'h0000, 15'h0000, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
      add(1'b0, 15'h0008, 8'd3, 15'h0000, 15'h0000, 1'b1, 1'b1, 15'h0008, 15'h0000, 1'b1, 1'b0, 4'd3, 1'b1, 1'b0);
      add(1'b0, 15'h0000, 8'd3, 15'h0008, 15'h0000, 1'b1, 1'b1, 15'h0000, 15'h0008, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
      add(1'b0, 15'h0000, 8'd3, 15'h0008, 15'h0000, 1'b1, 1'b1, 15'h0000, 15'h0008, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
      add(1'b0, 15'h0000, 8'd3, 15'h0008, 15'h0000, 1'b1, 1'b1, 15'h0000, 15'h0008, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
      add(1'b0, 15'h0000, 8'd3, 15'h0008, 15'h0008, 1'b1, 1'b1, 15'h0000, 15'h0008, 1'b0, 1'b1, 4'd3, 1'b1, 1'b0);
      add(1'b0, 15'h0000, 8'd0, 15'h0000, 15'h0000, 1'b1, 1'b1, 15'h0000, 15'h0000, 1'b0, 1'b0, 4'd3, 1'b0, 1'b0);
      // Round robin: masters 0, 5, 14 request continuously with single-beat bursts.
      add(1'b1, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h0000, 15'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0);
      add(1'b0, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h0001, 15'h0000, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0);
      add(1'b0, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h0000, 15'h0001, 1'b0, 1'b1, 4'd0,  1'b1, 1'b0);
      add(1'b0, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h0000, 15'h0000, 1'b0, 1'b0, 4'd0,  1'b0, 1'b0);
      add(1'b0, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h0020, 15'h0000, 1'b1, 1'b0, 4'd5,  1'b1, 1'b0);
      add(1'b0, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h0000, 15'h0020, 1'b0, 1'b1, 4'd5,  1'b1, 1'b0);
      add(1'b0, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h0000, 15'h0000, 1'b0, 1'b0, 4'd5,  1'b0, 1'b0);
      add(1'b0, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h4000, 15'h0000, 1'b1, 1'b0, 4'd14, 1'b1, 1'b0);
      add(1'b0, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h0000, 15'h4000, 1'b0, 1'b1, 4'd14, 1'b1, 1'b0);
      add(1'b0, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h0000, 15'h0000, 1'b0, 1'b0, 4'd14, 1'b0, 1'b0);
      add(1'b0, 15'h4021, 8'd0, 15'h4021, 15'h4021, 1'b1, 1'b1, 15'h0001, 15'h0000, 1'b1, 1'b0, 4'd0,  1'b1, 1'b0);

      do_reset();
      foreach (vecs[i]) begin
         if (vecs[i].rst) do_reset();
         set_in(vecs[i].aw, vecs[i].len, vecs[i].wv, vecs[i].wl, vecs[i].sar, vecs[i].swr);
         @(negedge aclk);
         chk($sformatf("vec%0d", i), 64'(cur()), 64'(vecs[i].exp));
         step();
      end

      // W lock: master 7 requests during master 2's 8-beat burst.
      do_reset();
      lens[2] = 8'd7; m_awvalid = 15'h0004; s_awready = 1'b1; s_wready = 1'b1;
      @(negedge aclk); step();
      m_awvalid = 15'h0084; m_wvalid = 15'h0080;
      @(negedge aclk);
      chk("wlock_addr_awready", 64'(m_awready), 64'h0004);
      chk("wlock_grant2", 64'(grant_idx), 64'd2);
      step();
      m_awvalid = 15'h0080;
      viol = 0;
      for (int b = 0; b < 8; b++) begin
         m_wvalid = 15'h0084;
         m_wlast  = (b == 7) ? 15'h0004 : 15'h0000;
         @(negedge aclk);
         if (m_awready[7] || m_wready[7] || !m_wready[2]) viol++;
         step();
      end
      chk("wlock_hold", 64'(viol), 64'd0);
      m_wlast = 15'h0; m_wvalid = 15'h0080;
      @(negedge aclk);
      chk("wlock_idle_wready", 64'(m_wready), 64'd0);
      chk("wlock_idle_busy", 64'(busy), 64'd0);
      step();
      @(negedge aclk);
      chk("wlock_next_grant", 64'(grant_idx), 64'd7);
      chk("wlock_next_awready", 64'(m_awready), 64'h0080);
      step();

      // Backpressure: AWREADY low 5 cycles, then WREADY toggling.
      do_reset();
      lens[1] = 8'd3; m_awvalid = 15'h0002; s_awready = 1'b0; s_wready = 1'b0;
      @(negedge aclk); step();
      addr_ok = 0;
      for (int c = 0; c < 5; c++) begin
         @(negedge aclk);
         if (busy && s_awvalid && (m_awready == 15'h0) && (grant_idx == 4'd1)) addr_ok++;
         step();
      end
      chk("bp_addr_hold", 64'(addr_ok), 64'd5);
      s_awready = 1'b1;
      @(negedge aclk);
      chk("bp_aw_handshake", 64'(m_awready), 64'h0002);
      step();
      m_awvalid = 15'h0; s_awready = 1'b0;
      acc = 0; badready = 0; errs = 0; done = 1'b0;
      for (int c = 0; c < 30 && !done; c++) begin
         s_wready = (c % 2 == 1);
         m_wvalid = (acc < 4) ? 15'h0002 : 15'h0000;
         m_wlast  = (acc == 3) ? 15'h0002 : 15'h0000;
         @(negedge aclk);
         if (!busy) begin
            done = 1'b1;
         end else begin
            if (m_wready !== (s_wready ? 15'h0002 : 15'h0000)) badready++;
            if (s_wvalid && s_wready) acc++;
         end
         if (wlast_err) errs++;
         step();
      end
      chk("bp_completed", 64'(done), 64'd1);
      chk("bp_beats", 64'(acc), 64'd4);
      chk("bp_wready_gating", 64'(badready), 64'd0);
      chk("bp_no_err", 64'(errs), 64'd0);

      // Reset mid-burst, then masters 0 and 9 request together.
      do_reset();
      lens[4] = 8'd15; m_awvalid = 15'h0010; s_awready = 1'b1; s_wready = 1'b1;
      @(negedge aclk); step();
      @(negedge aclk); step();
      m_awvalid = 15'h0; m_wvalid = 15'h0010;
      @(negedge aclk); step();
      @(negedge aclk);
      chk("rst_pre_wvalid", 64'(s_wvalid), 64'd1);
      #1 aresetn = 1'b0;
      #1;
      chk("rst_async_outputs", 64'(cur()), 64'd0);
      m_wvalid = 15'h0; lens[4] = 8'd0;
      @(posedge aclk);
      #1 aresetn = 1'b1;
      m_awvalid = 15'h0201;
      @(negedge aclk);
      chk("rst_after_idle", 64'(busy), 64'd0);
      step();
      @(negedge aclk);
      chk("rst_after_grant", 64'(grant_idx), 64'd0);
      chk("rst_after_awready", 64'(m_awready), 64'h0001);
      step();

      // Length checks.
      do_reset();
      run_len("len_early_wlast", 0, 8'd3, 2, 8'b0000_0010);
      run_len("len_late_wlast", 6, 8'd1, 3, 8'b0000_0110);
      run_len("len_exact", 3, 8'd3, 4, 8'b0000_0000);

      $display("Simulation finished: %0d checks, %0d errors", nchecks, nerrs);
      $finish;
   end
endmodule
